// File: rtl/cb_pkg.sv
// Shared helpers for the parametrised Y-channel connection block: derived sizes
// and the track-tap mapping used to wire each input-pin mux.
package cb_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    function automatic int total_bits(input int num_ipin, input int mux_size);
        return num_ipin * clog2(mux_size);
    endfunction

    function automatic int stride_of(input int chan_width, input int mux_size);
        return chan_width / (mux_size / 2);
    endfunction

    // Odd pins are offset by one track so neighbouring pins see different tracks.
    function automatic int track_of(input int i, input int j, input int chan_width, input int stride);
        return ((i % 2) + j * stride) % chan_width;
    endfunction

endpackage

// File: rtl/cb_ipin_mux.sv
// One MUX_SIZE:1 input-pin routing mux with a binary select; any select value
// at or beyond MUX_SIZE drives 0.
module cb_ipin_mux #(
    parameter int MUX_SIZE = 8,
    parameter int SEL_BITS = 3
) (
    input  logic [MUX_SIZE-1:0] data,
    input  logic [SEL_BITS-1:0] sel,
    output logic                pin
);

    // A compare-per-input form keeps the out-of-range case at 0 without any
    // out-of-bounds indexing.
    always_comb begin
        pin = 1'b0;
        for (int k = 0; k < MUX_SIZE; k++) begin
            if (int'(sel) == k) begin
                pin = data[k];
            end
        end
    end

endmodule

// File: rtl/cby_param_cb.sv
// Parametrised Y-channel connection block: track pass-through, NUM_IPIN pin muxes
// and a counted configuration chain. Optional parity bit: CBY_CFG_PARITY_EN.
module cby_param_cb
    import cb_pkg::*;
#(
    parameter int CHAN_WIDTH = 20,
    parameter int NUM_IPIN   = 8,
    parameter int MUX_SIZE   = 8,
    parameter int STRIDE     = stride_of(CHAN_WIDTH, MUX_SIZE)
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  config_enable,
    input  logic                  ccff_head,
    input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
    input  logic [CHAN_WIDTH-1:0] chany_top_in,
    output logic [CHAN_WIDTH-1:0] chany_bottom_out,
    output logic [CHAN_WIDTH-1:0] chany_top_out,
    output logic [NUM_IPIN-1:0]   ipin_out,
`ifdef CBY_CFG_PARITY_EN
    output logic                  cfg_parity_err,
`endif
    output logic                  ccff_tail,
    output logic                  cfg_done
);

    localparam int SEL_BITS   = clog2(MUX_SIZE);
    localparam int TOTAL_BITS = total_bits(NUM_IPIN, MUX_SIZE);
`ifdef CBY_CFG_PARITY_EN
    localparam int CHAIN_LEN  = TOTAL_BITS + 1;
`else
    localparam int CHAIN_LEN  = TOTAL_BITS;
`endif
    localparam int CNT_W = clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN_LEN);

    logic [CHAIN_LEN-1:0] cfg;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_cnt_next;
    logic [CNT_W-1:0]     cnt_base;
    logic                 cfg_done_next;
    logic                 en_prev;
    logic                 en_rise;
    logic [NUM_IPIN-1:0]  pin_raw;

    assign chany_bottom_out = chany_top_in;
    assign chany_top_out    = chany_bottom_in;
    assign ccff_tail        = cfg[CHAIN_LEN-1];

    // A new session restarts the count, and its first shift already counts as one.
    always_comb begin
        en_rise       = config_enable & ~en_prev;
        cnt_base      = en_rise ? '0 : bit_cnt;
        bit_cnt_next  = bit_cnt;
        cfg_done_next = cfg_done;
        if (config_enable) begin
            bit_cnt_next  = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + CNT_W'(1);
            cfg_done_next = (en_rise ? 1'b0 : cfg_done) | (bit_cnt_next == CNT_MAX);
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            cfg      <= '0;
            bit_cnt  <= '0;
            cfg_done <= 1'b0;
            en_prev  <= 1'b0;
        end else begin
            en_prev  <= config_enable;
            bit_cnt  <= bit_cnt_next;
            cfg_done <= cfg_done_next;
            if (config_enable) begin
                cfg <= {cfg[CHAIN_LEN-2:0], ccff_head};
            end
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_IPIN; gi++) begin : g_pin
            logic [MUX_SIZE-1:0] taps;
            for (gj = 0; gj < MUX_SIZE / 2; gj++) begin : g_tap
                assign taps[2*gj]   = chany_bottom_in[track_of(gi, gj, CHAN_WIDTH, STRIDE)];
                assign taps[2*gj+1] = chany_top_in[track_of(gi, gj, CHAN_WIDTH, STRIDE)];
            end
            cb_ipin_mux #(
                .MUX_SIZE(MUX_SIZE),
                .SEL_BITS(SEL_BITS)
            ) u_mux (
                .data(taps),
                .sel (cfg[gi*SEL_BITS +: SEL_BITS]),
                .pin (pin_raw[gi])
            );
        end
    endgenerate

    // Blank the grid pins for the whole session so partial selects never escape.
    assign ipin_out = pin_raw & ~{NUM_IPIN{config_enable}};

`ifdef CBY_CFG_PARITY_EN
    assign cfg_parity_err = cfg_done & ~config_enable & (^cfg);
`endif

endmodule
